disease_name_streamer: RTL and testbench
========================================

Name: disease_name_streamer

Overview:
- Holds the 15 chest X-ray class names in an internal parametrised ROM and streams one name at a time as 8-bit ASCII characters over a valid/ready handshake.
- Trailing pad spaces are stripped, and an optional CR/LF terminator is appended.
- Sits between the classifier argmax stage and the UART/console text path.
- Replaces the static full-width name lookup with a byte stream that supports backpressure.

Parameters:
- NUM_CLASSES, 15, number of ROM entries; class indices 0..NUM_CLASSES-1.
- NAME_LENGTH, 32, characters per ROM entry; names are space-padded on the right.
- APPEND_NEWLINE, 1, 1 = append 0x0D then 0x0A after each name; 0 = no terminator.
- IDX_W, $clog2(NUM_CLASSES+1), width of the request index, so out-of-range values are representable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  a class-name request is present.
- req_ready  out  1  block is idle and can accept a request.
- req_class  in  IDX_W  class index to print.
- out_valid  out  1  out_char holds a valid character.
- out_ready  in  1  downstream accepts out_char this cycle.
- out_char  out  8  ASCII character.
- out_last  out  1  marks the final character of the current message.
- busy  out  1  a message is in progress (not IDLE).
- name_len  out  $clog2(NAME_LENGTH+1)  trimmed length of the last accepted name; 1 for an invalid request.
- err_invalid  out  1  sticky flag for the current message: the request index was >= NUM_CLASSES.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, out_char=0x00, out_last=0, busy=0, name_len=0, err_invalid=0; req_ready=1 after reset release.
  - Reset asserted mid-message aborts the message immediately. No further characters are emitted, and the message is not resumed.
- ROM contents, index:name:
  - 0 No Finding, 1 Infiltration, 2 Atelectasis, 3 Effusion, 4 Nodule
  - 5 Pneumothorax, 6 Mass, 7 Consolidation, 8 Pleural Thickening, 9 Cardiomegaly
  - 10 Emphysema, 11 Fibrosis, 12 Edema, 13 Pneumonia, 14 Hernia
  - First character is stored in the most significant byte; each entry is padded with 0x20 to NAME_LENGTH.
- Trimmed length:
  - Defined as the index of the last non-space character + 1; internal spaces are kept ("Pleural Thickening" = 18).
  - Computed per entry as a constant table, not by a runtime scan.
- States: IDLE, NAME, TERM_CR, TERM_LF.
- IDLE:
  - req_ready=1, out_valid=0.
  - On req_valid && req_ready, latch the index, set name_len and err_invalid, load the first character into out_char, set out_valid=1, and go to NAME.
  - First character is presented the cycle after acceptance (latency 1).
- Invalid index (>= NUM_CLASSES): stream a single '?' (0x3F) and set err_invalid=1.
- Zero-length name (all spaces):
  - With APPEND_NEWLINE=1, go directly to TERM_CR.
  - With APPEND_NEWLINE=0, emit a single 0x20 with out_last=1.
- NAME:
  - Each out_valid && out_ready advances the character pointer.
  - After the last trimmed character, go to TERM_CR (APPEND_NEWLINE=1) or IDLE (APPEND_NEWLINE=0).
- TERM_CR emits 0x0D, then TERM_LF emits 0x0A.
- out_last is asserted only on the final beat: 0x0A, or the last name character when APPEND_NEWLINE=0.
- Backpressure: while out_valid && !out_ready, out_char, out_last and state hold stable. out_valid never deasserts until the beat is taken.
- Throughput: one character per cycle while out_ready=1.
- After the final handshake, return to IDLE with out_valid=0 for at least one cycle, so back-to-back requests have one bubble.
- Requests while busy: req_ready=0, and req_valid is ignored. The requester holds req_valid/req_class until accepted.
- busy = (state != IDLE).
- name_len and err_invalid hold until the next accepted request.

Test Plan:
- Reset, then req_class=6 with out_ready=1 -> beats 'M'(0x4D),'a','s','s',0x0D,0x0A on 6 consecutive cycles starting 1 cycle after accept; out_last only on 0x0A; name_len=4; busy low after.
- req_class=8 with out_ready toggled 1,0,0,1,... -> 18 characters "Pleural Thickening" in order, internal space 0x20 present, no drops or duplicates, out_char stable during stalls; 20 beats total.
- req_class=15 -> '?',0x0D,0x0A; err_invalid=1; name_len=1; the next valid request (class 0) clears err_invalid and streams "No Finding".
- Second req_valid asserted during streaming of class 1 -> req_ready=0, request not accepted until 1 cycle after the 0x0A handshake; then the second name streams intact.
- rst_n pulled low after the 3rd beat of class 13 -> out_valid=0 asynchronously, all outputs at reset values, req_ready=1 after release, no residual characters.
- APPEND_NEWLINE=0 build, req_class=14 -> exactly 'H','e','r','n','i','a' with out_last on 'a', then IDLE.

Source files
------------

// File: rtl/disease_name_streamer.sv
// Streams one chest X-ray class name from a constant ROM as ASCII bytes over
// valid/ready, with trailing pad spaces removed and an optional CR/LF terminator.
module disease_name_streamer #(
  parameter int NUM_CLASSES    = 15,
  parameter int NAME_LENGTH    = 32,
  parameter int APPEND_NEWLINE = 1,
  parameter int IDX_W          = $clog2(NUM_CLASSES + 1),
  localparam int LN_W          = $clog2(NAME_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy,
  output logic [LN_W-1:0]  name_len,
  output logic             err_invalid
);

  localparam bit APPEND = (APPEND_NEWLINE != 0);

  typedef enum logic [1:0] {IDLE, NAME, TERM_CR, TERM_LF} state_t;

  // First character lives in the most significant byte; the rest is 0x20 padding.
  function automatic logic [8*NAME_LENGTH-1:0] rom_entry(input logic [IDX_W-1:0] idx);
    rom_entry = {NAME_LENGTH{8'h20}};
    case (int'(idx))
      0:  rom_entry[8*NAME_LENGTH-1 -: 8*10] = "No Finding";
      1:  rom_entry[8*NAME_LENGTH-1 -: 8*12] = "Infiltration";
      2:  rom_entry[8*NAME_LENGTH-1 -: 8*11] = "Atelectasis";
      3:  rom_entry[8*NAME_LENGTH-1 -: 8*8]  = "Effusion";
      4:  rom_entry[8*NAME_LENGTH-1 -: 8*6]  = "Nodule";
      5:  rom_entry[8*NAME_LENGTH-1 -: 8*12] = "Pneumothorax";
      6:  rom_entry[8*NAME_LENGTH-1 -: 8*4]  = "Mass";
      7:  rom_entry[8*NAME_LENGTH-1 -: 8*13] = "Consolidation";
      8:  rom_entry[8*NAME_LENGTH-1 -: 8*18] = "Pleural Thickening";
      9:  rom_entry[8*NAME_LENGTH-1 -: 8*12] = "Cardiomegaly";
      10: rom_entry[8*NAME_LENGTH-1 -: 8*9]  = "Emphysema";
      11: rom_entry[8*NAME_LENGTH-1 -: 8*8]  = "Fibrosis";
      12: rom_entry[8*NAME_LENGTH-1 -: 8*5]  = "Edema";
      13: rom_entry[8*NAME_LENGTH-1 -: 8*9]  = "Pneumonia";
      14: rom_entry[8*NAME_LENGTH-1 -: 8*6]  = "Hernia";
      default: ;
    endcase
  endfunction

  // Trimmed lengths as a constant table; entries beyond the named set are blank.
  function automatic logic [LN_W-1:0] name_trim(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0: name_trim = LN_W'(10);  1: name_trim = LN_W'(12);  2: name_trim = LN_W'(11);
      3: name_trim = LN_W'(8);   4: name_trim = LN_W'(6);   5: name_trim = LN_W'(12);
      6: name_trim = LN_W'(4);   7: name_trim = LN_W'(13);  8: name_trim = LN_W'(18);
      9: name_trim = LN_W'(12);  10: name_trim = LN_W'(9);  11: name_trim = LN_W'(8);
      12: name_trim = LN_W'(5);  13: name_trim = LN_W'(9);  14: name_trim = LN_W'(6);
      default: name_trim = '0;
    endcase
  endfunction

  function automatic logic [7:0] rom_char(input logic [IDX_W-1:0] idx, input logic [LN_W-1:0] pos);
    logic [8*NAME_LENGTH-1:0] e;
    e = rom_entry(idx);
    rom_char = 8'h20;
    if (int'(pos) < NAME_LENGTH) rom_char = e[8*(NAME_LENGTH-1-int'(pos)) +: 8];
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LN_W-1:0]  ptr_q, ptr_d;
  logic [LN_W-1:0]  len_q, len_d;
  logic [7:0]       char_q, char_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             hs, invalid;
  logic [LN_W-1:0]  new_len;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    char_d  = char_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = err_q;
    hs      = valid_q && out_ready;
    invalid = (int'(req_class) >= NUM_CLASSES);
    new_len = invalid ? LN_W'(1) : name_trim(req_class);
    case (state_q)
      IDLE: if (req_valid) begin
        idx_d   = req_class;
        ptr_d   = '0;
        len_d   = new_len;
        err_d   = invalid;
        valid_d = 1'b1;
        if (new_len == '0 && APPEND) begin
          state_d = TERM_CR;
          char_d  = 8'h0D;
          last_d  = 1'b0;
        end else begin
          // A blank name without terminator still emits one space so the message is never empty.
          state_d = NAME;
          char_d  = invalid ? 8'h3F : rom_char(req_class, '0);
          last_d  = !APPEND && (new_len <= LN_W'(1));
        end
      end
      NAME: if (hs) begin
        if (int'(ptr_q) + 1 < int'(len_q)) begin
          ptr_d  = ptr_q + 1'b1;
          char_d = rom_char(idx_q, ptr_q + 1'b1);
          last_d = !APPEND && (int'(ptr_q) + 2 == int'(len_q));
        end else if (APPEND) begin
          state_d = TERM_CR;
          char_d  = 8'h0D;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      TERM_CR: if (hs) begin
        state_d = TERM_LF;
        char_d  = 8'h0A;
        last_d  = 1'b1;
      end
      TERM_LF: if (hs) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      char_q  <= char_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_char    = char_q;
  assign out_last    = last_q;
  assign name_len    = len_q;
  assign err_invalid = err_q;

endmodule

// File: tb/tb_disease_name_streamer.sv
// Scoreboard bench: two streamer builds (with and without CR/LF) checked against
// a string-level model of the class-name messages.
module tb_disease_name_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       req_valid_a, req_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a, err_a;
  logic [3:0] req_class_a;
  logic [7:0] out_char_a;
  logic [5:0] name_len_a;
  logic       req_valid_b, req_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b, err_b;
  logic [3:0] req_class_b;
  logic [7:0] out_char_b;
  logic [5:0] name_len_b;

  disease_name_streamer dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_class(req_class_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_char(out_char_a), .out_last(out_last_a), .busy(busy_a),
    .name_len(name_len_a), .err_invalid(err_a));

  disease_name_streamer #(.APPEND_NEWLINE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_class(req_class_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_char(out_char_b), .out_last(out_last_b), .busy(busy_b),
    .name_len(name_len_b), .err_invalid(err_b));

  typedef struct packed {logic [7:0] ch; logic last;} beat_t;
  beat_t qa[$], qb[$];
  int total = 0, passed = 0, cyc = 0;
  int last_hs_a = -10, last_hs_b = -10;
  bit rnd_a = 0, rnd_b = 0;

  string names[15] = '{"No Finding", "Infiltration", "Atelectasis", "Effusion", "Nodule",
                       "Pneumothorax", "Mass", "Consolidation", "Pleural Thickening",
                       "Cardiomegaly", "Emphysema", "Fibrosis", "Edema", "Pneumonia", "Hernia"};

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    out_ready_a = rnd_a ? 1'($urandom % 2) : 1'b1;
    out_ready_b = rnd_b ? 1'($urandom % 2) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Message = name with trailing spaces removed, '?' for an out-of-range index,
  // then CR LF (build A) or last flag on the final character (build B).
  task automatic model_push(input bit b, input int c, output int nl);
    string s;
    int n;
    beat_t bt;
    if (c >= 15) s = "?";
    else s = names[c];
    n = s.len();
    while (n > 0 && s[n-1] == 8'h20) n--;
    nl = (c >= 15) ? 1 : n;
    for (int i = 0; i < n; i++) begin
      bt.ch = s[i];
      bt.last = b && (i == n - 1);
      if (b) qb.push_back(bt); else qa.push_back(bt);
    end
    if (b && n == 0) qb.push_back(beat_t'({8'h20, 1'b1}));
    if (!b) begin
      qa.push_back(beat_t'({8'h0D, 1'b0}));
      qa.push_back(beat_t'({8'h0A, 1'b1}));
    end
  endtask

  // Monitor for build A: pops on every handshake and checks stall stability.
  initial begin
    bit pv;
    logic [8:0] pb;
    beat_t e;
    pv = 0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        if (pv) begin
          chk("A stall valid hold", 32'(out_valid_a), 32'd1);
          chk("A stall data hold", 32'({out_char_a, out_last_a}), 32'(pb));
        end
        if (out_valid_a && out_ready_a) begin
          total++;
          if (qa.size() == 0) $display("FAIL A beat: unexpected char %h, expected none", out_char_a);
          else begin
            total--;
            e = qa.pop_front();
            chk("A beat char", 32'(out_char_a), 32'(e.ch));
            chk("A beat last", 32'(out_last_a), 32'(e.last));
            if (out_last_a) last_hs_a = cyc + 1;
          end
        end
        pv = out_valid_a && !out_ready_a;
        pb = {out_char_a, out_last_a};
      end
    end
  end

  // Monitor for build B.
  initial begin
    bit pv;
    logic [8:0] pb;
    beat_t e;
    pv = 0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 0;
      else begin
        if (pv) begin
          chk("B stall valid hold", 32'(out_valid_b), 32'd1);
          chk("B stall data hold", 32'({out_char_b, out_last_b}), 32'(pb));
        end
        if (out_valid_b && out_ready_b) begin
          total++;
          if (qb.size() == 0) $display("FAIL B beat: unexpected char %h, expected none", out_char_b);
          else begin
            total--;
            e = qb.pop_front();
            chk("B beat char", 32'(out_char_b), 32'(e.ch));
            chk("B beat last", 32'(out_last_b), 32'(e.last));
            if (out_last_b) last_hs_b = cyc + 1;
          end
        end
        pv = out_valid_b && !out_ready_b;
        pb = {out_char_b, out_last_b};
      end
    end
  end

  // Issue one request; returns once the first character is on the output.
  task automatic req(input bit b, input int c, input bit b2b);
    int nl, to, acc;
    to = 0;
    @(posedge clk); #1;
    if (b) begin req_class_b = 4'(c); req_valid_b = 1'b1; end
    else begin req_class_a = 4'(c); req_valid_a = 1'b1; end
    @(negedge clk);
    while (!(b ? req_ready_b : req_ready_a) && to < 1000) begin
      chk("busy while not ready", 32'(b ? busy_b : busy_a), 32'd1);
      to++;
      @(negedge clk);
    end
    if (!(b ? req_ready_b : req_ready_a)) begin
      total++;
      $display("FAIL req accept: timeout, got ready=0 expected 1");
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (b2b) chk("accept 1 cycle after last beat", 32'(acc), 32'((b ? last_hs_b : last_hs_a) + 1));
    model_push(b, c, nl);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    @(negedge clk);
    chk("first char latency", 32'(b ? out_valid_b : out_valid_a), 32'd1);
    chk("name_len", 32'(b ? name_len_b : name_len_a), 32'(nl));
    chk("err_invalid", 32'(b ? err_b : err_a), 32'(c >= 15));
    chk("busy during msg", 32'(b ? busy_b : busy_a), 32'd1);
  endtask

  task automatic wait_idle(input bit b);
    int to = 0;
    while ((b ? (busy_b || qb.size() != 0) : (busy_a || qa.size() != 0)) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 3000) begin
      total++;
      $display("FAIL idle wait: timeout, got busy/queue pending expected idle");
    end else chk("out_valid low in idle", 32'(b ? out_valid_b : out_valid_a), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_a = 0; req_class_a = 0; req_valid_b = 0; req_class_b = 0;
    out_ready_a = 1; out_ready_b = 1;
    #1;
    chk("reset out_valid", 32'(out_valid_a), 32'd0);
    chk("reset out_char", 32'(out_char_a), 32'd0);
    chk("reset out_last", 32'(out_last_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset name_len", 32'(name_len_a), 32'd0);
    chk("reset err_invalid", 32'(err_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready_a), 32'd1);

    req(0, 6, 0);  wait_idle(0);
    rnd_a = 1;
    req(0, 8, 0);  wait_idle(0);
    rnd_a = 0;
    req(0, 15, 0); wait_idle(0);
    req(0, 0, 0);  wait_idle(0);
    req(0, 1, 0);  req(0, 2, 1); wait_idle(0);

    rnd_a = 1;
    for (int i = 0; i < 20; i++) req(0, int'($urandom_range(0, 15)), i > 0);
    wait_idle(0);

    req(1, 14, 0); wait_idle(1);
    req(1, 15, 0); wait_idle(1);
    rnd_b = 1;
    for (int i = 0; i < 8; i++) req(1, int'($urandom_range(0, 15)), i > 0);
    wait_idle(1);

    // Abort "Pneumonia" after its third character has been taken.
    rnd_a = 0;
    req(0, 13, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid_a), 32'd0);
    chk("abort out_char", 32'(out_char_a), 32'd0);
    chk("abort out_last", 32'(out_last_a), 32'd0);
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort name_len", 32'(name_len_a), 32'd0);
    chk("abort err_invalid", 32'(err_a), 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no residual after abort", 32'(out_valid_a), 32'd0);
    end
    chk("req_ready after abort", 32'(req_ready_a), 32'd1);
    req(0, 4, 0); wait_idle(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
